// File: rtl/fetch_queue.sv
// Instruction fetch unit: issues one word-aligned fetch at a time and queues returned
// instructions with their PCs in a DEPTH-entry circular buffer toward decode.
module fetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     redirect,
   input  logic [31:0]              redirect_pc,
   output logic                     mem_req,
   output logic [31:0]              mem_addr,
   input  logic                     mem_gnt,
   input  logic                     mem_rvalid,
   input  logic [31:0]              mem_rdata,
   output logic                     out_valid,
   output logic [31:0]              out_instr,
   output logic [31:0]              out_pc,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam logic [PtrW:0] FullCnt = (PtrW + 1)'(DEPTH);

   typedef enum logic [1:0] {StIdle, StWait, StDrop} state_e;

   state_e            state_q, state_d;
   logic [31:0]       fetch_pc_q, fetch_pc_d;
   logic [31:0]       req_pc_q, req_pc_d;
   logic [PtrW:0]     count_q, count_d;
   logic [PtrW-1:0]   head_q, head_d;
   logic [PtrW-1:0]   tail_q, tail_d;
   logic [31:0]       instr_mem_q [DEPTH];
   logic [31:0]       pc_mem_q    [DEPTH];

   logic issue;
   logic push_en;
   logic pop_en;

   always_comb begin
      issue   = (state_q == StIdle) && rst && !redirect && (count_q < FullCnt);
      push_en = (state_q == StWait) && rst && !redirect && mem_rvalid;
      pop_en  = out_valid && out_ready && !redirect;
   end

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      req_pc_d   = req_pc_q;
      count_d    = count_q;
      head_d     = head_q;
      tail_d     = tail_q;

      if (redirect) begin
         count_d    = '0;
         head_d     = '0;
         tail_d     = '0;
         fetch_pc_d = {redirect_pc[31:2], 2'b00};
         // The outstanding response is either consumed now or must be dropped later.
         case (state_q)
            StWait:  state_d = mem_rvalid ? StIdle : StDrop;
            StDrop:  state_d = mem_rvalid ? StIdle : StDrop;
            default: state_d = state_q;
         endcase
      end else begin
         case (state_q)
            StIdle: begin
               if (issue && mem_gnt) begin
                  req_pc_d   = fetch_pc_q;
                  fetch_pc_d = fetch_pc_q + 32'd4;
                  state_d    = StWait;
               end
            end
            StWait:  if (mem_rvalid) state_d = StIdle;
            StDrop:  if (mem_rvalid) state_d = StIdle;
            default: state_d = StIdle;
         endcase

         if (push_en) tail_d = tail_q + PtrW'(1);
         if (pop_en)  head_d = head_q + PtrW'(1);
         case ({push_en, pop_en})
            2'b10:   count_d = count_q + (PtrW + 1)'(1);
            2'b01:   count_d = count_q - (PtrW + 1)'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= StIdle;
         fetch_pc_q <= RESET_PC;
         req_pc_q   <= '0;
         count_q    <= '0;
         head_q     <= '0;
         tail_q     <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         req_pc_q   <= req_pc_d;
         count_q    <= count_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
      end
   end

   // Payload storage needs no reset; validity is tracked by count_q.
   always_ff @(posedge clk) begin
      if (push_en) begin
         instr_mem_q[tail_q] <= mem_rdata;
         pc_mem_q[tail_q]    <= req_pc_q;
      end
   end

   always_comb begin
      mem_req   = issue;
      mem_addr  = fetch_pc_q;
      out_valid = rst && (count_q != '0);
      out_instr = out_valid ? instr_mem_q[head_q] : 32'h0000_0000;
      out_pc    = out_valid ? pc_mem_q[head_q] : 32'h0000_0000;
      count     = count_q;
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a cycle-by-cycle vector table followed by a
// memory-responder sequence that fills the queue and drains it in order.
module tb_fetch_queue;

   logic        clk = 1'b0;
   logic        rst, redirect, mem_gnt, mem_rvalid, out_ready;
   logic [31:0] redirect_pc, mem_rdata;
   logic        mem_req, out_valid;
   logic [31:0] mem_addr, out_instr, out_pc;
   logic [2:0]  count;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
      .clk         (clk),
      .rst         (rst),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_gnt     (mem_gnt),
      .mem_rvalid  (mem_rvalid),
      .mem_rdata   (mem_rdata),
      .out_valid   (out_valid),
      .out_instr   (out_instr),
      .out_pc      (out_pc),
      .out_ready   (out_ready),
      .count       (count)
   );

   typedef struct {
      logic        rst, redir;
      logic [31:0] rpc;
      logic        gnt, rv;
      logic [31:0] rdata;
      logic        rdy;
      logic        req;
      logic [31:0] addr;
      logic        ov;
      logic [31:0] instr, pc;
      logic [2:0]  cnt;
   } vec_t;

   localparam int NVec = 27;
   vec_t vecs [NVec];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   initial begin
      logic        outstanding;
      logic [31:0] out_addr;
      int          grants, npop;
      bit          first_seen;

      //            rst redir rpc           gnt rv  rdata          rdy  req addr          ov instr          pc            cnt
      vecs[0]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,   1'b0, 32'h0,         32'h0,   3'd0};
      vecs[1]  = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0,   1'b0, 32'h0,         32'h0,   3'd0};
      vecs[2]  = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h1111_0000, 1'b1, 1'b0, 32'h4,   1'b0, 32'h0,         32'h0,   3'd0};
      vecs[3]  = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h4,   1'b1, 32'h1111_0000, 32'h0,   3'd1};
      vecs[4]  = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h1111_0001, 1'b1, 1'b0, 32'h8,   1'b0, 32'h0,         32'h0,   3'd0};
      vecs[5]  = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h8,   1'b1, 32'h1111_0001, 32'h4,   3'd1};
      vecs[6]  = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 32'h1111_0002, 1'b1, 1'b0, 32'hC,   1'b0, 32'h0,         32'h0,   3'd0};
      vecs[7]  = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'hC,   1'b1, 32'h1111_0002, 32'h8,   3'd1};
      vecs[8]  = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'hC,   1'b1, 32'h1111_0002, 32'h8,   3'd1};
      vecs[9]  = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'hC,   1'b1, 32'h1111_0002, 32'h8,   3'd1};
      vecs[10] = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'hC,   1'b1, 32'h1111_0002, 32'h8,   3'd1};
      vecs[11] = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 32'h1111_0003, 1'b1, 1'b0, 32'h10,  1'b0, 32'h0,         32'h0,   3'd0};
      vecs[12] = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h10,  1'b1, 32'h1111_0003, 32'hC,   3'd1};
      vecs[13] = '{1'b1, 1'b1, 32'h103, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h14,  1'b1, 32'h1111_0003, 32'hC,   3'd1};
      vecs[14] = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h100, 1'b0, 32'h0,         32'h0,   3'd0};
      vecs[15] = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h100, 1'b0, 32'h0,         32'h0,   3'd0};
      vecs[16] = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 32'h2222_0000, 1'b0, 1'b0, 32'h104, 1'b0, 32'h0,         32'h0,   3'd0};
      vecs[17] = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h104, 1'b1, 32'h2222_0000, 32'h100, 3'd1};
      vecs[18] = '{1'b1, 1'b1, 32'h40,  1'b0, 1'b1, 32'h2222_0001, 1'b1, 1'b0, 32'h108, 1'b1, 32'h2222_0000, 32'h100, 3'd1};
      vecs[19] = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h40,  1'b0, 32'h0,         32'h0,   3'd0};
      vecs[20] = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 32'h3333_0000, 1'b0, 1'b0, 32'h44,  1'b0, 32'h0,         32'h0,   3'd0};
      vecs[21] = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h44,  1'b1, 32'h3333_0000, 32'h40,  3'd1};
      vecs[22] = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 32'h3333_0001, 1'b0, 1'b0, 32'h48,  1'b1, 32'h3333_0000, 32'h40,  3'd1};
      vecs[23] = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h48,  1'b1, 32'h3333_0000, 32'h40,  3'd2};
      vecs[24] = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h4C,  1'b0, 32'h0,         32'h0,   3'd2};
      vecs[25] = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h0,   1'b0, 32'h0,         32'h0,   3'd0};
      vecs[26] = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0,   1'b0, 32'h0,         32'h0,   3'd0};

      rst = 1'b0; redirect = 1'b0; redirect_pc = '0; mem_gnt = 1'b0;
      mem_rvalid = 1'b0; mem_rdata = '0; out_ready = 1'b0;
      repeat (2) @(posedge clk);

      for (int i = 0; i < NVec; i++) begin
         @(negedge clk);
         rst = vecs[i].rst;   redirect = vecs[i].redir; redirect_pc = vecs[i].rpc;
         mem_gnt = vecs[i].gnt; mem_rvalid = vecs[i].rv; mem_rdata = vecs[i].rdata;
         out_ready = vecs[i].rdy;
         #1;
         chk($sformatf("v%0d.mem_req", i),   32'(mem_req),   32'(vecs[i].req));
         chk($sformatf("v%0d.mem_addr", i),  mem_addr,       vecs[i].addr);
         chk($sformatf("v%0d.out_valid", i), 32'(out_valid), 32'(vecs[i].ov));
         chk($sformatf("v%0d.out_instr", i), out_instr,      vecs[i].instr);
         chk($sformatf("v%0d.out_pc", i),    out_pc,         vecs[i].pc);
         chk($sformatf("v%0d.count", i),     32'(count),     32'(vecs[i].cnt));
      end

      // Fill: decode stalled, memory grants at once and answers one cycle later.
      @(negedge clk);
      rst = 1'b0; redirect = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; out_ready = 1'b0;
      outstanding = 1'b0; out_addr = '0; grants = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         rst = 1'b1; mem_gnt = 1'b1; out_ready = 1'b0;
         mem_rvalid = outstanding; mem_rdata = 32'hF000_0000 | out_addr;
         #1;
         if (mem_req) chk("fill.single_outstanding", 32'(outstanding), 32'd0);
         if (mem_req && mem_gnt) begin
            grants++; out_addr = mem_addr; outstanding = 1'b1;
         end else if (mem_rvalid) begin
            outstanding = 1'b0;
         end
      end
      chk("fill.grants",    32'(grants),    32'd4);
      chk("fill.count",     32'(count),     32'd4);
      chk("fill.mem_req",   32'(mem_req),   32'd0);
      chk("fill.head_pc",   out_pc,         32'h0);
      chk("fill.head_inst", out_instr,      32'hF000_0000);

      // Drain in order; the next fetch must continue at 0x10.
      npop = 0; first_seen = 1'b0;
      for (int c = 0; c < 40 && npop < 5; c++) begin
         @(negedge clk);
         mem_gnt = 1'b1; out_ready = 1'b1;
         mem_rvalid = outstanding; mem_rdata = 32'hF000_0000 | out_addr;
         #1;
         if (out_valid) begin
            chk($sformatf("drain%0d.pc", npop),    out_pc,    32'(4 * npop));
            chk($sformatf("drain%0d.instr", npop), out_instr, 32'hF000_0000 | 32'(4 * npop));
            npop++;
         end
         if (mem_req && mem_gnt) begin
            if (!first_seen) chk("drain.resume_addr", mem_addr, 32'h10);
            first_seen = 1'b1; out_addr = mem_addr; outstanding = 1'b1;
         end else if (mem_rvalid) begin
            outstanding = 1'b0;
         end
      end
      chk("drain.pops", 32'(npop), 32'd5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
